chip8_ram_arbiter: RTL and testbench

Single-port program/sprite RAM arbiter sitting between the 4K x 8 synchronous RAM and its three masters: the host ROM loader, the CPU and the blitter. Grants at most one access per clock with fixed priority for the loader and round-robin between CPU and blitter. Supports short locked bursts so the blitter can stream sprite rows, or the CPU can run FX65/FX33 sequences, without interleaving. All RAM-side outputs are registered; the arbiter fully owns the RAM pins.

---
 rtl/chip8_ram_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_chip8_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_ram_arbiter.sv
// chip8_ram_arbiter: owns the single-port 4K x 8 program/sprite RAM and shares
// it between the ROM loader (fixed top priority), the CPU and the blitter
// (round-robin). A granted beat can lock the RAM for a short burst; the lock
// is force-released after MAX_LOCK granted beats. RAM pins are registered.
module chip8_ram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_ack,
  output logic              ld_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  input  logic              blt_req,
  input  logic              blt_wr,
  input  logic [ADDR_W-1:0] blt_addr,
  input  logic [DATA_W-1:0] blt_wdata,
  input  logic              blt_lock,
  output logic              blt_ack,
  output logic              blt_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        owner,
  output logic              lock_abort
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_LD   = 2'd1;
  localparam logic [1:0] ID_CPU  = 2'd2;
  localparam logic [1:0] ID_BLT  = 2'd3;
  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  state_t              state_r, state_nxt_s;
  logic [1:0]          lock_own_r, lock_own_nxt_s;
  logic [7:0]          lock_cnt_r, lock_cnt_nxt_s;
  logic [7:0]          lock_cnt_inc_s;
  logic                abort_nxt_s;
  logic                rr_blt_last_r;   // 1: blitter was granted last, cpu wins a tie
  logic [1:0]          grant_s;
  logic                own_req_s, own_lock_s;
  logic                sel_wr_s, sel_lock_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [1:0]          tag1_r, tag2_r;  // read-owner pipe aligned with RAM latency

  assign ld_ack     = (grant_s == ID_LD);
  assign cpu_ack    = (grant_s == ID_CPU);
  assign blt_ack    = (grant_s == ID_BLT);
  assign ld_rvalid  = (tag2_r == ID_LD);
  assign cpu_rvalid = (tag2_r == ID_CPU);
  assign blt_rvalid = (tag2_r == ID_BLT);
  assign rdata      = ram_dout;
  assign lock_cnt_inc_s = lock_cnt_r + 8'd1;

  // Pick out the lock holder's request and lock lines.
  always_comb begin
    own_req_s  = 1'b0;
    own_lock_s = 1'b0;
    case (lock_own_r)
      ID_LD:   begin own_req_s = ld_req;  own_lock_s = ld_lock;  end
      ID_CPU:  begin own_req_s = cpu_req; own_lock_s = cpu_lock; end
      ID_BLT:  begin own_req_s = blt_req; own_lock_s = blt_lock; end
      default: begin own_req_s = 1'b0;    own_lock_s = 1'b0;     end
    endcase
  end

  // Grant decision from requests and state only (never from lock lines or RAM data).
  always_comb begin
    grant_s = ID_NONE;
    if (state_r == ST_LOCKED) begin
      if (own_req_s) grant_s = lock_own_r;
      else           grant_s = ID_NONE;
    end else begin
      if (ld_req)                   grant_s = ID_LD;
      else if (cpu_req && blt_req)  grant_s = rr_blt_last_r ? ID_CPU : ID_BLT;
      else if (cpu_req)             grant_s = ID_CPU;
      else if (blt_req)             grant_s = ID_BLT;
      else                          grant_s = ID_NONE;
    end
  end

  // Route the granted master's beat towards the RAM pin registers.
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_lock_s  = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    case (grant_s)
      ID_LD: begin
        sel_wr_s = ld_wr; sel_lock_s = ld_lock; sel_addr_s = ld_addr; sel_wdata_s = ld_wdata;
      end
      ID_CPU: begin
        sel_wr_s = cpu_wr; sel_lock_s = cpu_lock; sel_addr_s = cpu_addr; sel_wdata_s = cpu_wdata;
      end
      ID_BLT: begin
        sel_wr_s = blt_wr; sel_lock_s = blt_lock; sel_addr_s = blt_addr; sel_wdata_s = blt_wdata;
      end
      default: begin
        sel_wr_s = 1'b0; sel_lock_s = 1'b0;
        sel_addr_s = {ADDR_W{1'b0}}; sel_wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Lock FSM: enter on a locked grant, leave on unlock, idle release or beat limit.
  always_comb begin
    state_nxt_s    = state_r;
    lock_own_nxt_s = lock_own_r;
    lock_cnt_nxt_s = lock_cnt_r;
    abort_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((grant_s != ID_NONE) && sel_lock_s) begin
          state_nxt_s    = ST_LOCKED;
          lock_own_nxt_s = grant_s;
          lock_cnt_nxt_s = 8'd1;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (own_req_s) begin
          if (lock_cnt_inc_s == MAX_LOCK_C) begin
            state_nxt_s    = ST_IDLE;
            lock_cnt_nxt_s = 8'd0;
            abort_nxt_s    = 1'b1;
          end else if (!own_lock_s) begin
            state_nxt_s    = ST_IDLE;
            lock_cnt_nxt_s = 8'd0;
          end else begin
            lock_cnt_nxt_s = lock_cnt_inc_s;
          end
        end else if (!own_lock_s) begin
          state_nxt_s    = ST_IDLE;
          lock_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s    = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        lock_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      lock_own_r <= ID_NONE;
      lock_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      lock_own_r <= lock_own_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
    end
  end

  // Round-robin pointer, reported owner and force-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_blt_last_r <= 1'b1;
      owner         <= ID_NONE;
      lock_abort    <= 1'b0;
    end else begin
      if (grant_s == ID_CPU)      rr_blt_last_r <= 1'b0;
      else if (grant_s == ID_BLT) rr_blt_last_r <= 1'b1;
      else                        rr_blt_last_r <= rr_blt_last_r;
      if (grant_s != ID_NONE) owner <= grant_s;
      else                    owner <= owner;
      lock_abort <= abort_nxt_s;
    end
  end

  // RAM pin registers; address and data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_addr <= {ADDR_W{1'b0}};
      ram_din  <= {DATA_W{1'b0}};
    end else if (grant_s != ID_NONE) begin
      ram_en   <= 1'b1;
      ram_wr   <= sel_wr_s;
      ram_addr <= sel_addr_s;
      ram_din  <= sel_wdata_s;
    end else begin
      ram_en   <= 1'b0;
      ram_wr   <= 1'b0;
    end
  end

  // Two-stage read tag pipe so rvalid lands with ram_dout two cycles after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_r <= ID_NONE;
      tag2_r <= ID_NONE;
    end else begin
      tag1_r <= ((grant_s != ID_NONE) && !sel_wr_s) ? grant_s : ID_NONE;
      tag2_r <= tag1_r;
    end
  end

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// Scoreboard bench for chip8_ram_arbiter: stimulus pushes expected acks, RAM
// strobes, read returns, owner values and abort pulses (each stamped with the
// cycle they must appear in); one monitor pops and compares on every DUT event.
module tb_chip8_ram_arbiter;

  typedef struct {int cyc; logic [31:0] val;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  bit   done = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  exp_t q_ack[$], q_rv[$], q_ram[$], q_ab[$], q_own[$], q_z[$], q4_ack[$], q4_ab[$];

  // main DUT stimulus (index 1 ld, 2 cpu, 3 blt)
  logic [3:1]  req_v = '0, wr_v = '0, lock_v = '0;
  logic [11:0] addr_v [1:3];
  logic [7:0]  wd_v   [1:3];
  // second DUT (MAX_LOCK = 4) stimulus
  logic [3:1]  f_req_v = '0, f_wr_v = '0, f_lock_v = '0;
  logic [11:0] f_addr_v [1:3];
  logic [7:0]  f_wd_v   [1:3];

  logic ld_ack, cpu_ack, blt_ack, ld_rvalid, cpu_rvalid, blt_rvalid;
  logic [7:0] rdata, ram_din, ram_dout;
  logic [11:0] ram_addr;
  logic ram_en, ram_wr, lock_abort;
  logic [1:0] owner;

  logic f_ld_ack, f_cpu_ack, f_blt_ack, f_ld_rvalid, f_cpu_rvalid, f_blt_rvalid;
  logic [7:0] f_rdata, f_ram_din;
  logic [11:0] f_ram_addr;
  logic f_ram_en, f_ram_wr, f_lock_abort;
  logic [1:0] f_owner;

  logic [7:0] mem [0:4095];

  chip8_ram_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(req_v[1]), .ld_wr(wr_v[1]), .ld_addr(addr_v[1]), .ld_wdata(wd_v[1]), .ld_lock(lock_v[1]),
    .ld_ack(ld_ack), .ld_rvalid(ld_rvalid),
    .cpu_req(req_v[2]), .cpu_wr(wr_v[2]), .cpu_addr(addr_v[2]), .cpu_wdata(wd_v[2]), .cpu_lock(lock_v[2]),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .blt_req(req_v[3]), .blt_wr(wr_v[3]), .blt_addr(addr_v[3]), .blt_wdata(wd_v[3]), .blt_lock(lock_v[3]),
    .blt_ack(blt_ack), .blt_rvalid(blt_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .owner(owner), .lock_abort(lock_abort)
  );

  chip8_ram_arbiter #(.MAX_LOCK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .ld_req(f_req_v[1]), .ld_wr(f_wr_v[1]), .ld_addr(f_addr_v[1]), .ld_wdata(f_wd_v[1]), .ld_lock(f_lock_v[1]),
    .ld_ack(f_ld_ack), .ld_rvalid(f_ld_rvalid),
    .cpu_req(f_req_v[2]), .cpu_wr(f_wr_v[2]), .cpu_addr(f_addr_v[2]), .cpu_wdata(f_wd_v[2]), .cpu_lock(f_lock_v[2]),
    .cpu_ack(f_cpu_ack), .cpu_rvalid(f_cpu_rvalid),
    .blt_req(f_req_v[3]), .blt_wr(f_wr_v[3]), .blt_addr(f_addr_v[3]), .blt_wdata(f_wd_v[3]), .blt_lock(f_lock_v[3]),
    .blt_ack(f_blt_ack), .blt_rvalid(f_blt_rvalid),
    .rdata(f_rdata), .ram_en(f_ram_en), .ram_wr(f_ram_wr), .ram_addr(f_ram_addr), .ram_din(f_ram_din),
    .ram_dout(8'h00), .owner(f_owner), .lock_abort(f_lock_abort)
  );

  always #5 clk = ~clk;

  // cycle counter: value k names the cycle between posedge k and posedge k+1
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous write-first RAM model, preloaded with addr[7:0] ^ 0x3C
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h3C;
    end else if (ram_en) begin
      if (ram_wr) begin
        mem[ram_addr] <= ram_din;
        ram_dout      <= ram_din;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  function automatic logic [31:0] id_of(input logic [2:0] v);
    case (v)
      3'b001:  return 32'd1;
      3'b010:  return 32'd2;
      3'b100:  return 32'd3;
      default: return 32'd7;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // pop an event expectation when the DUT shows that event, comparing cycle and value
  task automatic pop_cmp(inout exp_t q[$], input string nm, input logic [31:0] got);
    exp_t e;
    if (q.size() == 0) begin
      chk({nm, "_unexpected"}, got | 32'h8000_0000, 32'd0);
    end else begin
      e = q.pop_front();
      chk({nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
      chk({nm, "_value"}, got, e.val);
    end
  endtask

  // monitor: every negedge, compare whatever the DUTs present against the queues
  always @(negedge clk) begin
    if (done || cyc > 4000) begin
      if (!done) chk("timeout", 32'(cyc), 32'd4000);
      chk("left_ack", 32'(q_ack.size()), 32'd0);
      chk("left_rvalid", 32'(q_rv.size()), 32'd0);
      chk("left_ram", 32'(q_ram.size()), 32'd0);
      chk("left_abort", 32'(q_ab.size() + q4_ab.size()), 32'd0);
      chk("left_ack4", 32'(q4_ack.size()), 32'd0);
      chk("left_owner_zero", 32'(q_own.size() + q_z.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end else begin
      if ({blt_ack, cpu_ack, ld_ack} != 3'b000)
        pop_cmp(q_ack, "ack", id_of({blt_ack, cpu_ack, ld_ack}));
      if ({blt_rvalid, cpu_rvalid, ld_rvalid} != 3'b000)
        pop_cmp(q_rv, "rvalid", (id_of({blt_rvalid, cpu_rvalid, ld_rvalid}) << 8) | 32'(rdata));
      if (ram_en)
        pop_cmp(q_ram, "ram", 32'({ram_wr, ram_addr, ram_din}));
      if (lock_abort)
        pop_cmp(q_ab, "abort", 32'd1);
      if ({f_blt_ack, f_cpu_ack, f_ld_ack} != 3'b000)
        pop_cmp(q4_ack, "ack4", id_of({f_blt_ack, f_cpu_ack, f_ld_ack}));
      if (f_lock_abort)
        pop_cmp(q4_ab, "abort4", 32'd1);
      while (q_own.size() != 0 && q_own[0].cyc <= cyc) begin
        chk("owner", 32'(owner), q_own.pop_front().val);
      end
      while (q_z.size() != 0 && q_z[0].cyc <= cyc) begin
        chk("reset_zero", 32'({ram_en, ram_wr, ram_addr, ram_din, owner, lock_abort,
                               ld_ack, cpu_ack, blt_ack, ld_rvalid, cpu_rvalid, blt_rvalid}),
            q_z.pop_front().val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit second, input int p, input bit rq, input bit w,
                       input logic [11:0] a, input logic [7:0] d, input bit lk);
    if (second) begin
      f_req_v[p] = rq; f_wr_v[p] = w; f_addr_v[p] = a; f_wd_v[p] = d; f_lock_v[p] = lk;
    end else begin
      req_v[p] = rq; wr_v[p] = w; addr_v[p] = a; wd_v[p] = d; lock_v[p] = lk;
    end
  endtask

  // expected grant this cycle: ack now, RAM strobe next cycle, read data two cycles on
  task automatic beat(input int id, input bit w, input logic [11:0] a,
                      input logic [7:0] d, input logic [7:0] rexp);
    q_ack.push_back('{cyc, 32'(id)});
    q_ram.push_back('{cyc + 1, 32'({w, a, d})});
    if (!w) q_rv.push_back('{cyc + 2, (32'(id) << 8) | 32'(rexp)});
  endtask

  initial begin
    logic [7:0] burst_exp [0:4];
    burst_exp = '{8'h6C, 8'h6D, 8'h6E, 8'h6F, 8'h68};
    for (int p = 1; p <= 3; p++) begin
      addr_v[p] = 12'h000; wd_v[p] = 8'h00; f_addr_v[p] = 12'h000; f_wd_v[p] = 8'h00;
    end

    // reset values
    repeat (2) step();
    q_z.push_back('{cyc, 32'd0});
    step();
    rst_n = 1'b1;
    step();

    // priority: ld wins three cycles, then cpu/blt alternate starting with cpu
    drive(0, 1, 1, 0, 12'h010, 8'h00, 0);
    drive(0, 2, 1, 0, 12'h020, 8'h00, 0);
    drive(0, 3, 1, 0, 12'h030, 8'h00, 0);
    beat(1, 0, 12'h010, 8'h00, 8'h2C); step();
    drive(0, 1, 1, 0, 12'h011, 8'h00, 0);
    beat(1, 0, 12'h011, 8'h00, 8'h2D); step();
    drive(0, 1, 1, 0, 12'h012, 8'h00, 0);
    beat(1, 0, 12'h012, 8'h00, 8'h2E); step();
    drive(0, 1, 0, 0, 12'h000, 8'h00, 0);
    beat(2, 0, 12'h020, 8'h00, 8'h1C); q_own.push_back('{cyc + 1, 32'd2}); step();
    drive(0, 2, 1, 0, 12'h021, 8'h00, 0);
    beat(3, 0, 12'h030, 8'h00, 8'h0C); step();
    drive(0, 3, 1, 0, 12'h031, 8'h00, 0);
    beat(2, 0, 12'h021, 8'h00, 8'h1D); step();
    drive(0, 2, 0, 0, 12'h000, 8'h00, 0);
    beat(3, 0, 12'h031, 8'h00, 8'h0D); q_own.push_back('{cyc + 1, 32'd3}); step();
    drive(0, 3, 0, 0, 12'h000, 8'h00, 0);
    step();

    // locked blitter burst 0x050..0x054 while ld and cpu wait
    for (int i = 0; i < 5; i++) begin
      drive(0, 3, 1, 0, 12'h050 + 12'(i), 8'h00, (i < 4));
      if (i == 1) begin
        drive(0, 1, 1, 0, 12'h0F0, 8'h00, 0);
        drive(0, 2, 1, 0, 12'h0E0, 8'h00, 0);
      end
      beat(3, 0, 12'h050 + 12'(i), 8'h00, burst_exp[i]);
      step();
    end
    drive(0, 3, 0, 0, 12'h000, 8'h00, 0);
    beat(1, 0, 12'h0F0, 8'h00, 8'hCC); q_own.push_back('{cyc + 1, 32'd1}); step();
    drive(0, 1, 0, 0, 12'h000, 8'h00, 0);
    beat(2, 0, 12'h0E0, 8'h00, 8'hDC); step();
    drive(0, 2, 0, 0, 12'h000, 8'h00, 0);
    step();

    // forced release on the MAX_LOCK = 4 instance
    for (int i = 0; i < 10; i++) begin
      drive(1, 3, 1, 0, 12'h100 + 12'(i), 8'h00, 1);
      if (i == 1) drive(1, 2, 1, 0, 12'h1E0, 8'h00, 0);
      if (i == 5) drive(1, 2, 0, 0, 12'h000, 8'h00, 0);
      if (i == 0 || i == 5) q4_ab.push_back('{cyc + 4, 32'd1});
      q4_ack.push_back('{cyc, (i == 4) ? 32'd2 : 32'd3});
      step();
    end
    drive(1, 3, 0, 0, 12'h000, 8'h00, 0);
    repeat (2) step();

    // write then read back, alternating, same address
    drive(0, 2, 1, 1, 12'h300, 8'hA5, 0);
    beat(2, 1, 12'h300, 8'hA5, 8'h00); step();
    drive(0, 2, 1, 0, 12'h300, 8'h00, 0);
    beat(2, 0, 12'h300, 8'h00, 8'hA5); step();
    drive(0, 2, 1, 1, 12'h301, 8'h5B, 0);
    beat(2, 1, 12'h301, 8'h5B, 8'h00); step();
    drive(0, 2, 1, 0, 12'h301, 8'h00, 0);
    beat(2, 0, 12'h301, 8'h00, 8'h5B); step();
    drive(0, 2, 0, 0, 12'h000, 8'h00, 0);
    step();

    // cpu holds the lock with no request; blitter must wait
    drive(0, 2, 1, 0, 12'h400, 8'h00, 1);
    beat(2, 0, 12'h400, 8'h00, 8'h3C); step();
    drive(0, 2, 0, 0, 12'h400, 8'h00, 1);
    drive(0, 3, 1, 0, 12'h410, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      q_own.push_back('{cyc, 32'd2});
      step();
    end
    drive(0, 2, 0, 0, 12'h400, 8'h00, 0);
    step();
    beat(3, 0, 12'h410, 8'h00, 8'h2C); step();
    drive(0, 3, 0, 0, 12'h000, 8'h00, 0);
    repeat (2) step();

    // reset in the middle of a cpu read: outputs clear at once, no rvalid later
    drive(0, 2, 1, 0, 12'h123, 8'h00, 0);
    q_ack.push_back('{cyc, 32'd2});
    step();
    drive(0, 2, 0, 0, 12'h000, 8'h00, 0);
    rst_n = 1'b0;
    q_z.push_back('{cyc, 32'd0});
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    drive(0, 2, 1, 0, 12'h200, 8'h00, 0);
    beat(2, 0, 12'h200, 8'h00, 8'h3C); step();
    drive(0, 2, 0, 0, 12'h000, 8'h00, 0);
    repeat (4) step();
    done = 1'b1;
  end

endmodule
